// File: rtl/sw_pe_array_ctrl_p.sv
// Smith-Waterman PE-array controller: query load, systolic enable wavefront,
// global max tracking with row/column, and last-PE boundary export.
//   state | meaning
//   IDLE  | waiting for i_start
//   LOAD  | accepting query bases into s_bank
//   RUN   | each accepted t beat steps the array
//   DRAIN | feed zeros until the wavefront has left the array
//   DONE  | one-cycle result strobe
module sw_pe_array_ctrl_p #(
  parameter int N_PE     = 64,
  parameter int N_PE_LOG = 6,
  parameter int SCORE_W  = 10,
  parameter int COL_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_start,
  input  logic                      i_abort,
  input  logic                      i_stall,
  input  logic [1:0]                i_s,
  input  logic                      i_s_valid,
  input  logic                      i_s_last,
  output logic                      o_s_ready,
  input  logic [1:0]                i_t,
  input  logic                      i_t_valid,
  input  logic                      i_t_last,
  output logic                      o_t_ready,
  output logic [2*N_PE-1:0]         o_s_bank,
  output logic [N_PE-1:0]           o_pe_en,
  output logic                      o_pe_step,
  output logic [1:0]                o_pe_t,
  input  logic [SCORE_W*N_PE-1:0]   i_pe_v,
  output logic [SCORE_W-1:0]        o_bnd_v,
  output logic                      o_bnd_valid,
  output logic [SCORE_W-1:0]        o_max,
  output logic [N_PE_LOG-1:0]       o_max_row,
  output logic [COL_W-1:0]          o_max_col,
  output logic                      o_col_ovf,
  output logic                      o_valid,
  output logic                      o_busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]            state;
  logic [2*N_PE-1:0]     s_bank;
  logic [N_PE_LOG-1:0]   load_cnt;
  logic [N_PE_LOG-1:0]   last_idx;
  logic [N_PE-1:0]       active_mask;
  logic [N_PE-1:0]       en;
  logic [N_PE-1:0]       en_d;
  logic                  step_d;
  logic [COL_W-1:0]      col_cnt;
  logic [COL_W-1:0]      step_col_d;

  logic                  s_acc;
  logic                  load_last;
  logic                  t_acc;
  logic                  drain_step;
  logic                  step;
  logic                  eval;
  logic [N_PE-1:0]       en_nxt;
  logic [N_PE-1:0]       mask_nxt;
  logic [SCORE_W-1:0]    pe_v [N_PE];
  logic [SCORE_W-1:0]    best_v;
  logic [N_PE_LOG-1:0]   best_i;
  logic                  hit;

  assign o_s_ready  = (state == S_LOAD) & ~i_abort;
  assign s_acc      = o_s_ready & i_s_valid;
  assign load_last  = i_s_last | (load_cnt == N_PE_LOG'(N_PE - 1));

  assign o_t_ready  = (state == S_RUN) & ~i_stall & ~i_abort;
  assign t_acc      = o_t_ready & i_t_valid;
  // Once the wavefront has fully left the array there is nothing left to step.
  assign drain_step = (state == S_DRAIN) & ~i_stall & ~i_abort & (|en);
  assign step       = t_acc | drain_step;
  assign en_nxt     = {en[N_PE-2:0], t_acc} & active_mask;

  assign o_pe_step  = step;
  assign o_pe_t     = t_acc ? i_t : 2'b00;
  assign o_pe_en    = en;
  assign o_s_bank   = s_bank;
  assign o_busy     = (state != S_IDLE);
  assign o_valid    = (state == S_DONE) & ~i_abort;

  // PE outputs hold while stalled, so a pending evaluation waits for the stall to clear.
  assign eval        = step_d & ~i_stall & ~i_abort;
  assign o_bnd_valid = eval & en_d[last_idx];
  assign o_bnd_v     = o_bnd_valid ? pe_v[last_idx] : '0;

  always_comb begin
    for (int i = 0; i < N_PE; i++) begin
      pe_v[i]     = i_pe_v[i*SCORE_W +: SCORE_W];
      mask_nxt[i] = (i <= int'(load_cnt));
    end
  end

  always_comb begin
    best_v = o_max;
    best_i = '0;
    hit    = 1'b0;
    for (int i = 0; i < N_PE; i++) begin
      if (en_d[i] && (pe_v[i] > best_v)) begin
        best_v = pe_v[i];
        best_i = N_PE_LOG'(i);
        hit    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      s_bank      <= '0;
      load_cnt    <= '0;
      last_idx    <= '0;
      active_mask <= '0;
      en          <= '0;
      en_d        <= '0;
      step_d      <= 1'b0;
      col_cnt     <= '0;
      step_col_d  <= '0;
      o_max       <= '0;
      o_max_row   <= '0;
      o_max_col   <= '0;
      o_col_ovf   <= 1'b0;
    end else if (i_abort) begin
      state  <= S_IDLE;
      en     <= '0;
      en_d   <= '0;
      step_d <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            state     <= S_LOAD;
            s_bank    <= '0;
            load_cnt  <= '0;
            col_cnt   <= '0;
            en        <= '0;
            en_d      <= '0;
            step_d    <= 1'b0;
            o_max     <= '0;
            o_max_row <= '0;
            o_max_col <= '0;
            o_col_ovf <= 1'b0;
          end
        end
        S_LOAD: begin
          if (s_acc) begin
            s_bank[2*load_cnt +: 2] <= i_s;
            load_cnt                <= load_cnt + 1'b1;
            if (load_last) begin
              last_idx    <= load_cnt;
              active_mask <= mask_nxt;
              state       <= S_RUN;
            end
          end
        end
        S_RUN:   if (t_acc && i_t_last) state <= S_DRAIN;
        S_DRAIN: if ((en == '0) && (en_d == '0)) state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      // col_cnt keeps counting through DRAIN so step_col_d - i stays the true t index.
      if (step) begin
        en         <= en_nxt;
        en_d       <= en_nxt;
        step_col_d <= col_cnt;
        col_cnt    <= col_cnt + 1'b1;
        if (t_acc && (&col_cnt) && !i_t_last) o_col_ovf <= 1'b1;
      end
      if (!i_stall) step_d <= step;

      if (eval && hit) begin
        o_max     <= best_v;
        o_max_row <= best_i;
        o_max_col <= step_col_d - COL_W'(best_i);
      end
    end
  end

endmodule

// File: tb/tb_sw_pe_array_ctrl_p.sv
// Directed bench for sw_pe_array_ctrl_p with N_PE=4; a second instance with
// COL_W=3 shares all inputs so the column overflow flag can be observed.
module tb_sw_pe_array_ctrl_p;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0, i_abort = 1'b0, i_stall = 1'b0;
  logic [1:0]  i_s = '0, i_t = '0;
  logic        i_s_valid = 1'b0, i_s_last = 1'b0;
  logic        i_t_valid = 1'b0, i_t_last = 1'b0;
  logic [39:0] i_pe_v = '0;

  logic        o_s_ready, o_t_ready, o_pe_step, o_bnd_valid, o_col_ovf, o_valid, o_busy;
  logic [7:0]  o_s_bank;
  logic [3:0]  o_pe_en;
  logic [1:0]  o_pe_t;
  logic [9:0]  o_bnd_v, o_max;
  logic [1:0]  o_max_row;
  logic [15:0] o_max_col;

  logic        c3_s_ready, c3_t_ready, c3_pe_step, c3_bnd_valid, c3_col_ovf, c3_valid, c3_busy;
  logic [7:0]  c3_s_bank;
  logic [3:0]  c3_pe_en;
  logic [1:0]  c3_pe_t;
  logic [9:0]  c3_bnd_v, c3_max;
  logic [1:0]  c3_max_row;
  logic [2:0]  c3_max_col;

  sw_pe_array_ctrl_p #(.N_PE(4), .N_PE_LOG(2), .SCORE_W(10), .COL_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort), .i_stall(i_stall),
    .i_s(i_s), .i_s_valid(i_s_valid), .i_s_last(i_s_last), .o_s_ready(o_s_ready),
    .i_t(i_t), .i_t_valid(i_t_valid), .i_t_last(i_t_last), .o_t_ready(o_t_ready),
    .o_s_bank(o_s_bank), .o_pe_en(o_pe_en), .o_pe_step(o_pe_step), .o_pe_t(o_pe_t),
    .i_pe_v(i_pe_v), .o_bnd_v(o_bnd_v), .o_bnd_valid(o_bnd_valid), .o_max(o_max),
    .o_max_row(o_max_row), .o_max_col(o_max_col), .o_col_ovf(o_col_ovf),
    .o_valid(o_valid), .o_busy(o_busy));

  sw_pe_array_ctrl_p #(.N_PE(4), .N_PE_LOG(2), .SCORE_W(10), .COL_W(3)) dut_c3 (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort), .i_stall(i_stall),
    .i_s(i_s), .i_s_valid(i_s_valid), .i_s_last(i_s_last), .o_s_ready(c3_s_ready),
    .i_t(i_t), .i_t_valid(i_t_valid), .i_t_last(i_t_last), .o_t_ready(c3_t_ready),
    .o_s_bank(c3_s_bank), .o_pe_en(c3_pe_en), .o_pe_step(c3_pe_step), .o_pe_t(c3_pe_t),
    .i_pe_v(i_pe_v), .o_bnd_v(c3_bnd_v), .o_bnd_valid(c3_bnd_valid), .o_max(c3_max),
    .o_max_row(c3_max_row), .o_max_col(c3_max_col), .o_col_ovf(c3_col_ovf),
    .o_valid(c3_valid), .o_busy(c3_busy));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bases: A=0 C=1 G=2 T=3. Score: match +2, mismatch -1, gap -1, local.
  logic [1:0] s_q [4];
  logic [1:0] t_q [16];
  int         hmat [4][16];
  int         cur_ns, cur_nt, vmode, step_k;

  task automatic build_h();
    int d, u, l, h;
    for (int i = 0; i < cur_ns; i++) begin
      for (int j = 0; j < cur_nt; j++) begin
        d = ((i > 0 && j > 0) ? hmat[i-1][j-1] : 0) + ((s_q[i] == t_q[j]) ? 2 : -1);
        u = ((i > 0) ? hmat[i-1][j] : 0) - 1;
        l = ((j > 0) ? hmat[i][j-1] : 0) - 1;
        h = 0;
        if (d > h) h = d;
        if (u > h) h = u;
        if (l > h) h = l;
        hmat[i][j] = h;
      end
    end
  endtask

  // Monitor state, sampled on the falling edge.
  logic       step_prev = 1'b0;
  logic [3:0] en_log [$];
  int         cyc = 0, bnd_cnt, valid_cnt, first_t_cyc, last_t_cyc, valid_cyc;
  bit         first_taken, hi_en_seen, pe_t_bad;

  task automatic clear_log();
    en_log.delete();
    bnd_cnt = 0; valid_cnt = 0; first_t_cyc = 0; last_t_cyc = 0; valid_cyc = 0;
    first_taken = 0; hi_en_seen = 0; pe_t_bad = 0; step_k = 0;
  endtask

  always @(negedge clk) begin
    if (step_prev) en_log.push_back(o_pe_en);
    step_prev = o_pe_step;
    if (o_pe_step) begin
      if (o_t_ready && i_t_valid) pe_t_bad |= (o_pe_t != i_t);
      else                        pe_t_bad |= (o_pe_t != 2'b00);
    end
    if (o_t_ready && i_t_valid) begin
      if (!first_taken) begin first_t_cyc = cyc; first_taken = 1; end
      if (i_t_last) last_t_cyc = cyc;
    end
    if (o_bnd_valid) bnd_cnt++;
    if (o_valid) begin valid_cnt++; valid_cyc = cyc; end
    if (|o_pe_en[3:2]) hi_en_seen = 1;
    cyc++;
  end

  // PE chain stand-in: after each step, present that step's V values and hold them.
  logic [39:0] pv;
  int          val, jj;
  always @(posedge clk) begin
    #1;
    if (step_prev) begin
      pv = '0;
      for (int i = 0; i < 4; i++) begin
        jj  = step_k - i;
        val = 0;
        if (vmode == 1) begin
          if (i < cur_ns && jj >= 0 && jj < cur_nt) val = hmat[i][jj];
          else val = 1000;
        end else if (vmode == 2) begin
          if (step_k == 3 && (i == 1 || i == 2)) val = 9;
          else if (step_k == 5 && i == 3) val = 9;
          else if (step_k == 4 && i == 0) val = 8;
        end
        pv[i*10 +: 10] = 10'(val);
      end
      i_pe_v = pv;
      step_k++;
    end
  end

  task automatic run_job(input int ns, input int nt, input int stall_after, input bit abort_drain);
    cur_ns = ns; cur_nt = nt;
    build_h();
    clear_log();
    i_start = 1; tick(); i_start = 0;
    for (int b = 0; b < ns; b++) begin
      i_s = s_q[b]; i_s_valid = 1; i_s_last = (b == ns - 1); tick();
    end
    i_s_valid = 0; i_s_last = 0;
    for (int b = 0; b < nt; b++) begin
      i_t = t_q[b]; i_t_valid = 1; i_t_last = (b == nt - 1);
      if (b == stall_after) begin
        i_stall = 1;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("stall_t_ready", o_t_ready, 1'b0);
          check("stall_en", o_pe_en, 4'b0011);
          @(posedge clk); #1;
        end
        i_stall = 0;
      end
      tick();
    end
    i_t_valid = 0; i_t_last = 0;
    if (abort_drain) begin
      i_abort = 1;
      @(negedge clk);
      check("abort_valid", o_valid, 1'b0);
      @(posedge clk); #1;
      i_abort = 0;
      @(negedge clk);
      check("abort_busy", o_busy, 1'b0);
      check("abort_en", o_pe_en, 4'b0000);
      repeat (10) tick();
    end else begin
      for (int k = 0; k < 40; k++) begin
        tick();
        if (valid_cnt > 0) break;
      end
      tick(); tick();
    end
  endtask

  function automatic logic [31:0] pack_en();
    logic [31:0] p = '0;
    foreach (en_log[i]) p = (p << 4) | 32'(en_log[i]);
    return p;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    check("rst_busy", o_busy, 1'b0);
    check("rst_max", {o_max, o_max_row, o_max_col}, 0);
    check("rst_ready", {o_s_ready, o_t_ready}, 2'b00);
    check("rst_en", o_pe_en, 4'b0000);
    check("rst_strobes", {o_pe_step, o_valid, o_bnd_valid, o_col_ovf}, 4'b0000);
    check("rst_bank", o_s_bank, 8'h00);

    // ACGT vs ACGT, no stall
    s_q = '{2'd0, 2'd1, 2'd2, 2'd3};
    t_q[0] = 0; t_q[1] = 1; t_q[2] = 2; t_q[3] = 3;
    vmode = 1;
    run_job(4, 4, -1, 0);
    check("t1_en_count", en_log.size(), 8);
    check("t1_en_seq", pack_en(), 32'h137FEC80);
    check("t1_valid_cnt", valid_cnt, 1);
    check("t1_latency", valid_cyc - last_t_cyc, 6);
    check("t1_first_to_valid", valid_cyc - first_t_cyc, 9);
    check("t1_max", o_max, 10'd8);
    check("t1_row", o_max_row, 2'd3);
    check("t1_col", o_max_col, 16'd3);
    check("t1_bnd_cnt", bnd_cnt, 4);
    check("t1_pe_t", pe_t_bad, 1'b0);
    check("t1_bank", o_s_bank, 8'hE4);
    check("t1_busy", o_busy, 1'b0);

    // Query AC (2 bases) vs ACACA: only PE0/PE1 active
    s_q[0] = 0; s_q[1] = 1;
    t_q[0] = 0; t_q[1] = 1; t_q[2] = 0; t_q[3] = 1; t_q[4] = 0;
    run_job(2, 5, -1, 0);
    check("t2_en_seq", pack_en(), 32'h01333320);
    check("t2_hi_en", hi_en_seen, 1'b0);
    check("t2_bnd_cnt", bnd_cnt, 5);
    check("t2_latency", valid_cyc - last_t_cyc, 4);
    check("t2_max", {o_max, o_max_row, o_max_col}, {10'd4, 2'd1, 16'd1});
    check("t2_bank", o_s_bank, 8'h04);

    // Forced V: PE1 and PE2 both 9 at step 3, a later 9 on PE3
    s_q = '{2'd0, 2'd1, 2'd2, 2'd3};
    for (int b = 0; b < 6; b++) t_q[b] = 2'(b);
    vmode = 2;
    run_job(4, 6, -1, 0);
    check("t3_max", o_max, 10'd9);
    check("t3_row", o_max_row, 2'd1);
    check("t3_col", o_max_col, 16'd2);

    // Stall for 3 cycles after two t beats
    t_q[0] = 0; t_q[1] = 1; t_q[2] = 2; t_q[3] = 3;
    vmode = 1;
    run_job(4, 4, 2, 0);
    check("t4_first_to_valid", valid_cyc - first_t_cyc, 12);
    check("t4_latency", valid_cyc - last_t_cyc, 6);
    check("t4_max", {o_max, o_max_row, o_max_col}, {10'd8, 2'd3, 16'd3});

    // Abort in DRAIN, then a clean all-zero job with 9 t beats
    run_job(4, 4, -1, 1);
    check("t5_no_valid", valid_cnt, 0);
    for (int b = 0; b < 9; b++) t_q[b] = 2'(b % 4);
    vmode = 0;
    run_job(4, 9, -1, 0);
    check("t6_valid_cnt", valid_cnt, 1);
    check("t6_max", {o_max, o_max_row, o_max_col}, 0);
    check("t6_ovf16", o_col_ovf, 1'b0);
    check("t6_ovf3", c3_col_ovf, 1'b1);

    // Asynchronous reset in the middle of RUN
    t_q[0] = 0; t_q[1] = 1; t_q[2] = 2; t_q[3] = 3;
    vmode = 1; cur_ns = 4; cur_nt = 4;
    build_h();
    clear_log();
    i_start = 1; tick(); i_start = 0;
    for (int b = 0; b < 4; b++) begin
      i_s = s_q[b]; i_s_valid = 1; i_s_last = (b == 3); tick();
    end
    i_s_valid = 0; i_s_last = 0;
    for (int b = 0; b < 3; b++) begin
      i_t = t_q[b]; i_t_valid = 1; tick();
    end
    i_t_valid = 0;
    tick(); tick();
    @(negedge clk);
    check("t7_pre_max", {o_max, o_max_row, o_max_col}, {10'd4, 2'd1, 16'd1});
    check("t7_pre_busy", o_busy, 1'b1);
    #2 rst_n = 0;
    #1;
    check("t7_rst_busy", o_busy, 1'b0);
    check("t7_rst_max", {o_max, o_max_row, o_max_col}, 0);
    check("t7_rst_en", o_pe_en, 4'b0000);
    check("t7_rst_bank", o_s_bank, 8'h00);
    check("t7_rst_ready", {o_s_ready, o_t_ready, o_valid, o_bnd_valid}, 4'b0000);
    #10 rst_n = 1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
